child_response_collector: RTL
=============================

// Module: child_response_collector
// PURPOSE
// Fan-in counterpart to the generated fan-out hierarchy: a parent instantiates NUM_CHILDREN leaf
// instances, and each leaf writes result words on its own valid/ready channel. This block reads
// those channels, arbitrates round-robin, and emits one serialized, index-tagged stream. It also
// tracks which children have reported since the last clear, so the parent can detect completion.
// PARAMETERS
// NUM_CHILDREN  15  number of child request channels (2..64)
// DATA_W        16  width of each child result word
// CNT_W         16  width of saturating accepted-response counter
// PORTS
// clk          in   1                          single clock; all logic on rising edge
// rst_n        in   1                          synchronous, active-low reset
// child_valid  in   NUM_CHILDREN               per-child word valid
// child_data   in   NUM_CHILDREN*DATA_W        per-child word; child i at [i*DATA_W +: DATA_W]
// child_ready  out  NUM_CHILDREN               one-hot (or zero) accept strobe
// out_valid    out  1                          collected word valid
// out_ready    in   1                          downstream accept
// out_data     out  DATA_W                     collected word
// out_idx      out  IDX_W                      source child index, IDX_W = max(1, $clog2(NUM_CHILDREN))
// clear_seen   in   1                          clear the seen bitmap (1-cycle pulse)
// seen         out  NUM_CHILDREN               children accepted since reset or clear
// all_done     out  1                          registered: &seen
// rsp_count    out  CNT_W                      accepted words, saturating at all-ones
// BEHAVIOUR
// - Reset (rst_n=0 at edge):
//   - out_valid=0, out_data=0, out_idx=0, seen=0, all_done=0, rsp_count=0.
//   - last_grant=NUM_CHILDREN-1, so child 0 has top priority after reset.
//   - child_ready is combinational and is 0 while rst_n=0.
// - load = ~out_valid | out_ready. Output register is 1 entry, so full throughput is 1 word/cycle.
// - Grant: when load=1, search child_valid starting at last_grant+1 mod NUM_CHILDREN, wrapping;
//   the first set bit wins. child_ready = grant one-hot & {NUM_CHILDREN{load}}.
// - Accept (a child has valid & ready) at edge:
//   - out_data <= that child's data; out_idx <= its index; out_valid <= 1.
//   - last_grant <= winner; seen[winner] <= 1; rsp_count += 1 unless already all-ones.
// - Drain with no accept (out_valid & out_ready, no child valid): out_valid <= 0.
//   out_data and out_idx hold their values.
// - Stall (out_valid & ~out_ready): child_ready=0; out_* stay stable; last_grant is unchanged.
// - Latency: child accept at edge N gives out_valid at N (visible in cycle N+1).
//   There is no combinational path from child_data to out_data.
// - Combinational paths: out_ready -> child_ready is allowed and intended (bubble-free drain).
//   There is no path from child_valid to child_valid.
// - Fairness: a child held valid is granted within NUM_CHILDREN accepts.
// - Wrap-around: when last_grant=NUM_CHILDREN-1, the search starts at 0. Indices >= NUM_CHILDREN
//   never grant.
// - clear_seen: seen <= 0 on the next edge.
//   - If an accept happens in the same cycle, seen[winner] is set (accept wins for that bit only).
//   - all_done follows seen one cycle later.
// - Protocol: a child must hold valid and data stable until ready. The block does not check this.
// - Synchronous reset mid-transfer discards any held out word. No child is ready during reset.
// STRUCTURE
// - Package collector_pkg holds:
//   - function idx_w(n) returning max(1, $clog2(n));
//   - typedef logic [15:0] rsp_word_t (default DATA_W).
// - Sub-module rr_arbiter #(N), combinational:
//   - inputs req[N], base_idx, en;
//   - outputs gnt[N] one-hot and gnt_idx;
//   - implemented as a double-width masked priority encoder.
// - Top level holds the output register, last_grant, seen, all_done and rsp_count flops.
// TESTING
// - Reset, then child_valid=15'h0001, data 16'hA5A5, out_ready=1
//   -> child_ready[0]=1; next cycle out_valid=1, out_data=A5A5, out_idx=0, seen=15'h0001.
// - All 15 children valid continuously with out_ready=1
//   -> out_idx sequence 0,1,...,14,0; each child granted once per 15 accepts; all_done=1 after
//   15 accepts plus 1 cycle.
// - out_valid=1 with out_ready=0 for 5 cycles, children 3 and 7 valid
//   -> child_ready=0 throughout; out_data stable; on release child 3 is granted, then child 7.
// - last_grant=14 with children 14 and 2 valid -> child 2 is granted first (wrap).
// - clear_seen pulsed in the same cycle child 5 is accepted -> seen=15'h0020; all_done=0.
// - CNT_W=4 and 20 accepts -> rsp_count saturates at 4'hF.
// - Reset asserted while out_valid=1 -> out_valid=0 next edge and child_ready=0 during reset.
//   After release, child 0 has priority.

Source files
------------

// File: rtl/collector_pkg.sv
// Shared types and sizing helpers for the child response collector.
// Pulled in by the arbiter and the collector top.
package collector_pkg;

   typedef logic [15:0] rsp_word_t;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: double-width masked priority encoder.
// The search starts one past base_idx and wraps back to 0.
module rr_arbiter
   import collector_pkg::*;
#(
   parameter int N = 15,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base_idx,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] mask;
   logic [2*N-1:0] masked;
   int             start;
   int             win;
   logic           found;

   assign dbl = {req, req};

   always_comb begin
      start = (int'(base_idx) >= N - 1) ? 0 : int'(base_idx) + 1;
      for (int i = 0; i < 2 * N; i++) begin
         mask[i] = (i >= start);
      end
   end

   assign masked = dbl & mask;

   // Upper copy of req covers the wrapped part of the search.
   always_comb begin
      found = 1'b0;
      win   = 0;
      for (int i = 0; i < 2 * N; i++) begin
         if (!found && masked[i]) begin
            found = 1'b1;
            win   = (i >= N) ? i - N : i;
         end
      end
   end

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int j = 0; j < N; j++) begin
         gnt[j] = en && found && (win == j);
      end
      if (en && found) begin
         gnt_idx = IW'(win);
      end
   end

endmodule

// File: rtl/child_response_collector.sv
// Fan-in collector: round-robin merge of per-child result channels
// into one index-tagged stream, with seen/done tracking and counter.
module child_response_collector
   import collector_pkg::*;
#(
   parameter int NUM_CHILDREN = 15,
   parameter int DATA_W       = 16,
   parameter int CNT_W        = 16,
   localparam int IDX_W       = idx_w(NUM_CHILDREN)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CHILDREN-1:0]        child_valid,
   input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
   output logic [NUM_CHILDREN-1:0]        child_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_W-1:0]              out_data,
   output logic [IDX_W-1:0]               out_idx,
   input  logic                           clear_seen,
   output logic [NUM_CHILDREN-1:0]        seen,
   output logic                           all_done,
   output logic [CNT_W-1:0]               rsp_count
);

   logic                    out_valid_q;
   logic [DATA_W-1:0]       out_data_q;
   logic [IDX_W-1:0]        out_idx_q;
   logic [IDX_W-1:0]        last_q;
   logic [NUM_CHILDREN-1:0] seen_q;
   logic [NUM_CHILDREN-1:0] seen_d;
   logic                    done_q;
   logic [CNT_W-1:0]        cnt_q;

   logic                    load;
   logic                    accept;
   logic [NUM_CHILDREN-1:0] gnt;
   logic [IDX_W-1:0]        gnt_idx;
   logic [DATA_W-1:0]       data_sel;

   assign load = ~out_valid_q | out_ready;

   rr_arbiter #(
      .N(NUM_CHILDREN)
   ) u_arb (
      .req      (child_valid),
      .base_idx (last_q),
      .en       (load & rst_n),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx)
   );

   assign child_ready = gnt;
   assign accept      = |(gnt & child_valid);

   always_comb begin
      data_sel = '0;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
         if (gnt[i]) begin
            data_sel = child_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // An accept sets its own bit even when a clear lands in the same cycle.
   always_comb begin
      seen_d = clear_seen ? '0 : seen_q;
      if (accept) begin
         seen_d = seen_d | gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         last_q      <= IDX_W'(NUM_CHILDREN - 1);
         seen_q      <= '0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         seen_q <= seen_d;
         done_q <= &seen_q;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_sel;
            out_idx_q   <= gnt_idx;
            last_q      <= gnt_idx;
            if (cnt_q != '1) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign seen      = seen_q;
   assign all_done  = done_q;
   assign rsp_count = cnt_q;

endmodule
